// File: rtl/spi_frame_tx.sv
// spi_frame_tx
// ------------
// SPI mode-0 master that sends one two-byte register-write frame per request:
// an address byte followed by a data byte, MSB first, inside a single NSS-low
// window. The far-end slave commits the write when NSS returns high.
//
// Optional feature: define SPI_FRAME_TX_READBACK_EN to add the miso input and
// the rdata output. The slave's replies during the data byte are then captured
// and presented on rdata when the frame completes.
//
// Parameters
//   CLK_DIV  SCLK half-period in clk cycles (>= 1)
//   NSS_GAP  minimum clk cycles NSS stays high after a frame (>= 1)
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   start    in   frame request, sampled only while busy is low
//   addr     in   address byte, captured on the accepting edge
//   data     in   data byte, captured on the accepting edge
//   busy     out  high from the cycle after acceptance through the NSS gap
//   done     out  one-cycle pulse in the cycle NSS returns high
//   nss      out  slave select, active-low
//   sclk     out  SPI clock, idles low
//   mosi     out  serial data out, low whenever NSS is high
//   state    out  FSM state for debug (IDLE=0 SETUP=1 SHIFT=2 HOLD=3 GAP=4)
//   miso     in   serial data in (readback builds only)
//   rdata    out  captured data-byte reply (readback builds only)
//
// Timing (D = CLK_DIV): NSS is low for 34*D cycles (D setup, 16 bit periods
// of 2*D, D hold). MOSI changes only as SCLK falls, so it is stable D cycles
// either side of every rising SCLK edge.
module spi_frame_tx #(
  parameter int CLK_DIV = 4,
  parameter int NSS_GAP = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       nss,
  output logic       sclk,
  output logic       mosi,
  output logic [2:0] state
`ifdef SPI_FRAME_TX_READBACK_EN
  ,
  input  logic       miso,
  output logic [7:0] rdata
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GP_W = (NSS_GAP > 1) ? $clog2(NSS_GAP) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [GP_W-1:0] GP_LAST = GP_W'(NSS_GAP - 1);

  logic [15:0]     shreg;
  logic [PH_W-1:0] phase;
  logic [3:0]      bit_cnt;
  logic [GP_W-1:0] gap_cnt;
  logic            phase_end;

  assign phase_end = (phase == PH_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= 16'h0000;
      phase   <= '0;
      bit_cnt <= 4'd0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nss     <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy is always low here, so any start seen in IDLE is accepted.
          if (start) begin
            shreg   <= {addr, data};
            mosi    <= addr[7];
            nss     <= 1'b0;
            busy    <= 1'b1;
            phase   <= '0;
            bit_cnt <= 4'd0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          if (phase_end) begin
            phase <= '0;
            state <= SHIFT;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        SHIFT: begin
          if (phase_end) begin
            phase <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // Falling SCLK: present the next bit. The register rotates so
              // every bit of it stays live; after the last bit MOSI parks low.
              sclk    <= 1'b0;
              shreg   <= {shreg[14:0], shreg[15]};
              mosi    <= (bit_cnt == 4'd15) ? 1'b0 : shreg[14];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                state <= HOLD;
              end
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        HOLD: begin
          if (phase_end) begin
            phase   <= '0;
            nss     <= 1'b1;
            mosi    <= 1'b0;
            done    <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          nss   <= 1'b1;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_FRAME_TX_READBACK_EN
  logic [7:0] cap;

  // MISO is sampled on the clk edge that raises SCLK, data-byte bits only
  // (bit_cnt 8..15). rdata is published on the edge that raises NSS, so it
  // changes together with done and an aborted frame never reaches it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap   <= 8'h00;
      rdata <= 8'h00;
    end else begin
      if ((state == SHIFT) && phase_end && !sclk && bit_cnt[3]) begin
        cap <= {cap[6:0], miso};
      end
      if ((state == HOLD) && phase_end) begin
        rdata <= cap;
      end
    end
  end
`else
  // Without readback there is no MISO path and no capture logic.
`endif

endmodule

// File: doc/spi_frame_tx.md
# spi_frame_tx

- SPI mode-0 master that sends one two-byte write frame per request: an address byte, then a data byte, MSB first, framed by a single NSS low window.
- It is the initiator for the board's SPI register-write path. The far-end slave decodes NSS falling → address byte → data byte → NSS rising, then commits the write.
- Sits between local control logic (start/addr/data handshake) and the SPI pins.

## Interface

Parameters:
- CLK_DIV, default 4: SCLK half-period in clk cycles; legal range ≥1.
- NSS_GAP, default 2: minimum clk cycles NSS stays high after a frame before the next frame may begin; legal range ≥1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  frame request; sampled only while busy=0.
- addr  in  8  address byte, captured on the accepting edge.
- data  in  8  data byte, captured on the accepting edge.
- busy  out  1  high from the cycle after acceptance through the end of the NSS gap.
- done  out  1  one-cycle pulse when NSS returns high.
- nss  out  1  slave select, active-low.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  serial data out.
- state  out  3  current FSM state, for debug.
- miso  in  1  serial data in; present only with SPI_FRAME_TX_READBACK_EN.
- rdata  out  8  readback byte; present only with SPI_FRAME_TX_READBACK_EN.

## Operation

- All outputs are registered.
- Reset values: nss=1, sclk=0, mosi=0, busy=0, done=0, state=IDLE, rdata=0x00.
- The 16-bit shift register and all counters clear on reset.
- State encodings: IDLE=0, SETUP=1, SHIFT=2, HOLD=3, GAP=4.

State transitions:
- IDLE: on start=1, load shreg={addr,data}, drive mosi=addr[7] and nss=0, set busy=1, go to SETUP.
- SETUP: hold for CLK_DIV cycles with sclk=0, then go to SHIFT.
- SHIFT: runs 16 bit periods of 2·CLK_DIV cycles each.
  - Each period is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - mosi changes only on the sclk falling edge: it loads the next bit as sclk returns to 0.
  - After the 16th high phase, sclk returns to 0 and the FSM goes to HOLD.
- HOLD: hold for CLK_DIV cycles with sclk=0, then set nss=1, pulse done, go to GAP.
- GAP: hold for NSS_GAP cycles, then clear busy and go to IDLE.

Rules:
- start while busy=1 is ignored; it is neither queued nor latched.
- addr and data are don't-care after the accepting edge.
- The bit counter is 4 bits and counts 0..15. The phase counter counts 0..CLK_DIV-1 and wraps to 0.
- mosi is 0 whenever nss=1.
- Asserting reset_n low mid-frame forces nss=1 and sclk=0 immediately (asynchronously). The partial frame is abandoned and done is not pulsed. The next start after reset sends a complete frame.
- start=1 in the same cycle busy falls: busy is still 1 at that edge, so the start is ignored. Acceptance requires busy=0 at the sampling edge.

## Timing

- Acceptance edge T0: nss=0 and busy=1 are visible from cycle T0+1.
- NSS low window: exactly 34·CLK_DIV cycles (136 for CLK_DIV=4).
- SCLK: 16 rising edges per frame. The first rising edge occurs 2·CLK_DIV cycles after NSS falls.
- Setup and hold: MOSI is stable CLK_DIV cycles before, and CLK_DIV cycles after, every rising SCLK edge.
- done: asserted in the cycle nss first reads 1, i.e. T0+34·CLK_DIV+1.
- busy: high for 34·CLK_DIV+NSS_GAP cycles.
- Minimum start-to-start spacing: 34·CLK_DIV+NSS_GAP+1 cycles (139 with defaults).
- SCLK frequency = f_clk/(2·CLK_DIV).

## Configuration

- SPI_FRAME_TX_READBACK_EN defined:
  - miso and rdata ports exist.
  - miso is sampled at the clk edge that raises sclk, for bits 8..15 (the data byte) only, MSB first, into an 8-bit capture register.
  - rdata updates in the same cycle done asserts and holds until the next done.
  - Address-byte miso bits are discarded.
  - rdata is unchanged by an aborted (reset) frame, apart from reset clearing it to 0x00.
- SPI_FRAME_TX_READBACK_EN undefined:
  - miso and rdata ports are absent and no capture logic is built.
  - All other behaviour is identical.

## Test plan

- Single frame, defaults, addr=0x5A, data=0xC3 → mosi sampled on the 16 sclk rising edges = 0101_1010_1100_0011; nss low exactly 136 cycles; one done pulse at T0+137; busy low at T0+139.
- start held high continuously → frames begin at T0, T0+139 and T0+278 with identical waveforms; no extra done pulses.
- start pulsed at T0+50 during a frame with addr=0xFF → ignored; frame content unchanged; no second frame.
- reset_n low for 3 cycles at the 7th sclk rising edge → nss=1 and sclk=0 in the same cycle, no done pulse; a following start with addr=0x01, data=0x80 sends a full, correct frame.
- CLK_DIV=1, NSS_GAP=1 → nss low 34 cycles, sclk toggles every cycle, 16 rising edges, busy high 35 cycles.
- With SPI_FRAME_TX_READBACK_EN, miso driven 0xA5 during the data byte and 0xFF during the address byte → rdata=0xA5 in the cycle done asserts.
